dec_seq_cnt: RTL and testbench

- Loadable down-counter sequencer. Emits the coefficient/byte indices len-1, len-2, …, 0 over a valid/ready handshake, then pulses done.
- Used by Encaps/Decaps loops that walk arrays from the top index down.
- Counterpart of the incrementer: next-index logic is a combinational decrementer. It uses a Sklansky OR-prefix borrow chain rather than an AND-prefix carry chain.

---
 rtl/ntru_cnt_pkg.sv | 15 +
 rtl/dec_prefix_w.sv | 40 ++++
 rtl/dec_seq_cnt.sv | 112 +++++++++++
 tb/tb_dec_seq_cnt.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntru_cnt_pkg.sv
// Shared definitions for the NTRU index counters/sequencers.
package ntru_cnt_pkg;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dec_seq_state_t;

  // Coefficient count and index width of the 701-coefficient loops
  localparam int unsigned N_COEF = 701;
  localparam int unsigned IDX_W  = 10;

endpackage

// File: rtl/dec_prefix_w.sv
// W-bit combinational decrementer: y = a - 1 (wraps 0 -> all ones).
// Bit i flips when every lower bit is zero; that "any lower bit set" term is
// an OR-prefix computed with a Sklansky tree, log2(W-1) levels deep.
module dec_prefix_w
  import ntru_cnt_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_y
);

  if (W == 1) begin : g_w1
    // Single bit: decrement is a plain inversion
    assign o_y = ~i_a;
  end else begin : g_wn
    localparam int unsigned PW = W - 1;
    localparam int unsigned LV = $clog2(PW);

    logic [PW-1:0] w_p;

    // Sklansky OR-prefix over a[W-2:0]; the combine source at each level has
    // bit l clear, so it is never updated in that level and in-place is safe
    always_comb begin
      w_p = i_a[PW-1:0];
      for (int l = 0; l < int'(LV); l++) begin
        for (int i = 0; i < int'(PW); i++) begin
          if (((i >> l) & 1) == 1) begin
            w_p[i] = w_p[i] | w_p[((i >> l) << l) - 1];
          end
        end
      end
      o_y[0] = ~i_a[0];
      for (int i = 1; i < int'(W); i++) begin
        o_y[i] = i_a[i] ^ ~w_p[i-1];
      end
    end
  end

endmodule

// File: rtl/dec_seq_cnt.sv
// Loadable down-counter sequencer: emits len-1 .. 0 over valid/ready, then
// pulses done. Optional start-while-busy error pulse: define DEC_SEQ_ERR_EN.
module dec_seq_cnt
  import ntru_cnt_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] len,
  input  logic         abort,
  output logic [W-1:0] idx_o,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic         busy,
  output logic         done
`ifdef DEC_SEQ_ERR_EN
  ,
  output logic         err
`endif
);

  dec_seq_state_t r_state;
  logic [W-1:0]   r_idx;
  logic           r_valid;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   w_dec_in;
  logic [W-1:0]   w_dec;

  // One decrementer shared by the len load path and the index step
  assign w_dec_in = (r_state == IDLE) ? len : r_idx;

  dec_prefix_w #(.W(W)) u_dec (
    .i_a (w_dec_in),
    .o_y (w_dec)
  );

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (len != '0) begin
              r_idx   <= w_dec;
              r_valid <= 1'b1;
              r_state <= RUN;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (idx_ready) begin
            if (r_idx != '0) begin
              r_idx <= w_dec;
            end else begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef DEC_SEQ_ERR_EN
  logic r_err;

  // Flag a start request that arrives while a run is in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= start & r_busy;
    end
  end

  assign err = r_err;
`endif

  assign idx_o     = r_idx;
  assign idx_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_dec_seq_cnt.sv
// Directed self-checking bench for dec_seq_cnt (W=8) and dec_prefix_w.
module tb_dec_seq_cnt;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic [7:0] idx_o;
  logic       idx_valid;
  logic       idx_ready;
  logic       busy;
  logic       done;
`ifdef DEC_SEQ_ERR_EN
  logic       err;
`endif

  logic [7:0] dec_a;
  logic [7:0] dec_y;

  int n_chk;
  int n_err;

  dec_seq_cnt #(.W(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .idx_o     (idx_o),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .busy      (busy),
    .done      (done)
`ifdef DEC_SEQ_ERR_EN
    ,
    .err       (err)
`endif
  );

  dec_prefix_w #(.W(8)) u_dec (
    .i_a (dec_a),
    .o_y (dec_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int e_idx, input bit e_v,
                         input bit e_b, input bit e_d);
    if (e_idx >= 0) chk({tag, ".idx"}, 32'(idx_o), 32'(e_idx));
    chk({tag, ".valid"}, 32'(idx_valid), 32'(e_v));
    chk({tag, ".busy"}, 32'(busy), 32'(e_b));
    chk({tag, ".done"}, 32'(done), 32'(e_d));
  endtask

  logic rdy_pat [5];
  int   idx_pat [5];

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; len = 8'd0; abort = 1'b0; idx_ready = 1'b0;
    dec_a = 8'd0;

    // Exhaustive decrementer check
    for (int a = 0; a < 256; a++) begin
      dec_a = 8'(a);
      #1;
      chk("dec", 32'(dec_y), 32'((a + 255) % 256));
    end

    // Reset state
    step(); step();
    chk_out("reset", 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // len=4, ready held: 3,2,1,0 then done on the 5th edge after start
    len = 8'd4; start = 1'b1; idx_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      chk_out("len4", k, 1, 1, 0);
      step();
    end
    chk_out("len4_done", -1, 0, 1, 1);
    step();
    chk_out("len4_idle", -1, 0, 0, 0);

    // len=0: no index, done one cycle after start, busy only that cycle
    len = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk_out("len0_done", -1, 0, 1, 1);
    step();
    chk_out("len0_idle", -1, 0, 0, 0);

    // len=3 with ready 1,0,0,1,1: index holds while not accepted
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    idx_pat = '{2, 1, 1, 1, 0};
    len = 8'd3; start = 1'b1; idx_ready = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_out("len3_bp", idx_pat[k], 1, 1, 0);
      idx_ready = rdy_pat[k];
      step();
    end
    chk_out("len3_done", -1, 0, 1, 1);
    step();

    // len=255, ready held: 254 down to 0 across every borrow chain
    len = 8'd255; start = 1'b1; idx_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 254; k >= 0; k--) begin
      chk("len255.idx", 32'(idx_o), 32'(k));
      chk("len255.valid", 32'(idx_valid), 32'd1);
      step();
    end
    chk_out("len255_done", -1, 0, 1, 1);
    step();

    // len=8, abort with ready at idx 5: back to IDLE, idx kept, no done
    len = 8'd8; start = 1'b1; idx_ready = 1'b1;
    step();
    start = 1'b0;
    chk_out("abort_run", 7, 1, 1, 0);
    step(); step();
    chk_out("abort_at5", 5, 1, 1, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_out("abort_idle", 5, 0, 0, 0);
    step();
    chk_out("abort_nodone", 5, 0, 0, 0);
    len = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk_out("restart2", 1, 1, 1, 0);
    step();
    chk_out("restart2", 0, 1, 1, 0);
    step();
    chk_out("restart2_done", -1, 0, 1, 1);
    step();

    // Abort in IDLE is ignored
    abort = 1'b1; len = 8'd1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk_out("abort_idle_ign", 0, 1, 1, 0);
    step();
    chk_out("abort_idle_done", -1, 0, 1, 1);
    step();

    // Start while running is ignored (and flagged when enabled)
    len = 8'd3; start = 1'b1;
    step();
    len = 8'd9;
    chk_out("busy_start", 2, 1, 1, 0);
    step();
    start = 1'b0;
    chk_out("busy_start", 1, 1, 1, 0);
`ifdef DEC_SEQ_ERR_EN
    chk("err_pulse", 32'(err), 32'd1);
`endif
    step();
    chk_out("busy_start", 0, 1, 1, 0);
`ifdef DEC_SEQ_ERR_EN
    chk("err_clear", 32'(err), 32'd0);
`endif
    step();
    chk_out("busy_start_done", -1, 0, 1, 1);
    step();

    // Start during DONE is ignored; the following cycle is accepted
    len = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk_out("len1", 0, 1, 1, 0);
    step();
    chk_out("len1_done", -1, 0, 1, 1);
    len = 8'd2; start = 1'b1;
    step();
    chk_out("done_start_ign", -1, 0, 0, 0);
    step();
    start = 1'b0;
    chk_out("done_restart", 1, 1, 1, 0);
    step();
    chk_out("done_restart", 0, 1, 1, 0);
    step();
    chk_out("done_restart_done", -1, 0, 1, 1);
    step();

    // Reset mid-run: reset values on the next edge, no done afterwards
    len = 8'd8; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk_out("pre_reset", 5, 1, 1, 0);
    rst = 1'b1;
    step();
    chk_out("mid_reset", 0, 0, 0, 0);
`ifdef DEC_SEQ_ERR_EN
    chk("mid_reset.err", 32'(err), 32'd0);
`endif
    rst = 1'b0;
    step();
    chk_out("post_reset", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
